cnn_host_driver: RTL and testbench
==================================

CNN_HOST_DRIVER -- requirements
Module: cnn_host_driver

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the width of one feature-map word.
REQ-002 The block SHALL have parameter IN_WORDS, default 36, giving the number of input words per frame (6x6).
REQ-003 The block SHALL have parameter OUT_WORDS, default 9, giving the number of result words per frame (3x3).
REQ-004 The block SHALL have parameter TIMEOUT, default 255, giving the maximum wait for acc_done, in cycles.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port s_valid, input, 1 bit: an input-stream word is present.
REQ-008 The block SHALL have port s_ready, output, 1 bit: the block accepts an input-stream word.
REQ-009 The block SHALL have port s_data, input, DATA_W bits: the input-stream word, in row-major order.
REQ-010 The block SHALL have port acc_start, output, 1 bit: start pulse to the accelerator.
REQ-011 The block SHALL have port acc_done, input, 1 bit: done pulse from the accelerator.
REQ-012 The block SHALL have port acc_fm_in, output, IN_WORDS x DATA_W array: feature map driven to the accelerator.
REQ-013 The block SHALL have port acc_fm_out, input, OUT_WORDS x DATA_W array: pooled result from the accelerator.
REQ-014 The block SHALL have port m_valid, output, 1 bit: a result-stream word is present.
REQ-015 The block SHALL have port m_ready, input, 1 bit: the sink accepts a result word.
REQ-016 The block SHALL have port m_data, output, DATA_W bits: the result word.
REQ-017 The block SHALL have port m_last, output, 1 bit: marks result word OUT_WORDS-1.
REQ-018 The block SHALL have port err_timeout, output, 1 bit: one-cycle pulse when the accelerator wait times out.

Function
REQ-019 The FSM SHALL have exactly the states LOAD, START, WAIT and SEND.
REQ-020 In LOAD: s_ready=1; each cycle with s_valid&&s_ready SHALL write s_data into buffer[wr_idx] and increment wr_idx.
REQ-021 When the handshake accepts word IN_WORDS-1, the FSM SHALL go LOAD->START next cycle and clear wr_idx.
REQ-022 In START: acc_start=1 for exactly one cycle, s_ready=0, then unconditionally ->WAIT.
REQ-023 acc_fm_in SHALL be driven continuously from the buffer registers.
REQ-024 The buffer SHALL be written only in LOAD, so acc_fm_in is stable from START through SEND.
REQ-025 In WAIT: a cycle counter SHALL increment from 0; acc_done=1 SHALL capture all OUT_WORDS of acc_fm_out into result registers and go ->SEND.
REQ-026 In WAIT, if the counter reaches TIMEOUT with acc_done=0, the FSM SHALL go ->LOAD, pulse err_timeout for one cycle and leave the result registers unchanged.
REQ-027 If acc_done=1 on the same cycle the counter reaches TIMEOUT, done SHALL win: results are captured and no error is raised.
REQ-028 acc_done outside WAIT SHALL be ignored.
REQ-029 In SEND: m_valid=1, m_data=result[rd_idx], m_last=(rd_idx==OUT_WORDS-1); rd_idx SHALL advance only on m_valid&&m_ready.
REQ-030 m_data and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-031 On the handshake of the last word, the FSM SHALL go ->LOAD, with s_ready=1 on the next cycle.
REQ-032 s_ready SHALL be 0 and m_valid 0 outside LOAD and SEND respectively; s_valid outside LOAD SHALL be ignored.
REQ-033 Minimum frame turnaround SHALL be IN_WORDS + 1 (START) + accelerator latency + OUT_WORDS cycles; nominal acc_done latency is 2 cycles after acc_start.

Reset
REQ-034 While reset_n=0, independent of clk: state=LOAD; wr_idx, rd_idx and the wait counter SHALL be 0.
REQ-035 While reset_n=0: buffer and result registers SHALL be 0.
REQ-036 While reset_n=0: acc_start, m_valid, m_last and err_timeout SHALL be 0, and m_data SHALL be 0.
REQ-037 Reset asserted mid-frame SHALL discard the partial frame; the first word after release SHALL be stored at index 0.

Structure
REQ-038 The shared package cnn_pkg SHALL hold DATA_W, IN_WORDS, OUT_WORDS, the state enum and index widths ($clog2).
REQ-039 The block SHALL be one flat module with no sub-modules.

Verification
REQ-040 Bench SHALL stream words 1..36 back-to-back -> acc_start pulses once on the cycle after word 36, and acc_fm_in[k]=k+1.
REQ-041 Bench SHALL drive a model returning done after 2 cycles with results 100..108 and m_ready=1 -> 9 beats 100..108, m_last only on 108.
REQ-042 Bench SHALL toggle m_ready every other cycle -> m_data holds between beats and no word is lost or duplicated.
REQ-043 Bench SHALL never assert acc_done -> err_timeout pulses once TIMEOUT cycles after entering WAIT, and s_ready returns to 1.
REQ-044 Bench SHALL assert reset_n=0 after word 20, then stream a full frame -> the accelerator sees only the new 36 words.
REQ-045 Bench SHALL assert acc_done on the exact timeout cycle -> results are streamed and err_timeout stays 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN host driver: default frame geometry,
// controller state encoding and index-width helper.
package cnn_pkg;

  localparam int DATA_W    = 16;
  localparam int IN_WORDS  = 36;
  localparam int OUT_WORDS = 9;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } state_t;

  // Bits needed to index n entries (never less than one bit).
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int IN_IDX_W  = idx_w(IN_WORDS);
  localparam int OUT_IDX_W = idx_w(OUT_WORDS);

endpackage

// File: rtl/cnn_host_driver.sv
// Streams one feature map into a buffer, kicks the accelerator, waits for its
// done pulse (with timeout) and streams the pooled result back out.
module cnn_host_driver
  import cnn_pkg::*;
#(
  parameter int DATA_W    = cnn_pkg::DATA_W,
  parameter int IN_WORDS  = cnn_pkg::IN_WORDS,
  parameter int OUT_WORDS = cnn_pkg::OUT_WORDS,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              acc_start,
  input  logic              acc_done,
  output logic [DATA_W-1:0] acc_fm_in  [IN_WORDS],
  input  logic [DATA_W-1:0] acc_fm_out [OUT_WORDS],
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              err_timeout
);

  localparam int IW_W = idx_w(IN_WORDS);
  localparam int OW_W = idx_w(OUT_WORDS);
  localparam int TO_W = idx_w(TIMEOUT + 1);

  localparam logic [IW_W-1:0] WR_LAST = IW_W'(IN_WORDS - 1);
  localparam logic [OW_W-1:0] RD_LAST = OW_W'(OUT_WORDS - 1);
  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  logic [IW_W-1:0]   wr_idx;
  logic [OW_W-1:0]   rd_idx;
  logic [TO_W-1:0]   wait_cnt;
  logic [DATA_W-1:0] buffer [IN_WORDS];
  logic [DATA_W-1:0] result [OUT_WORDS];

  logic s_fire;
  logic m_fire;
  logic wr_last;
  logic rd_last;
  logic capture;

  assign wr_last = (wr_idx == WR_LAST);
  assign rd_last = (rd_idx == RD_LAST);
  assign s_fire  = (state == LOAD) && s_valid;
  assign m_fire  = (state == SEND) && m_ready;
  // A done pulse only counts while waiting; it beats a same-cycle timeout.
  assign capture = (state == WAIT) && acc_done;

  assign acc_fm_in = buffer;

  always_comb begin
    state_nxt   = state;
    s_ready     = 1'b0;
    acc_start   = 1'b0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_last      = 1'b0;
    err_timeout = 1'b0;
    case (state)
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid && wr_last) state_nxt = START;
      end
      START: begin
        acc_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (acc_done) begin
          state_nxt = SEND;
        end else if (wait_cnt == TO_LIM) begin
          err_timeout = 1'b1;
          state_nxt   = LOAD;
        end
      end
      SEND: begin
        m_valid = 1'b1;
        m_data  = result[rd_idx];
        m_last  = rd_last;
        if (m_ready && rd_last) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= LOAD;
      wr_idx   <= '0;
      rd_idx   <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (s_fire) wr_idx <= wr_last ? '0 : wr_idx + 1'b1;
      if (m_fire) rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
      // Counts cycles spent in WAIT; cleared on every exit.
      if ((state == WAIT) && (state_nxt == WAIT)) wait_cnt <= wait_cnt + 1'b1;
      else                                         wait_cnt <= '0;
    end
  end

  // Frame buffer is only written in LOAD, so it is stable for the accelerator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < IN_WORDS; k++) buffer[k] <= '0;
    end else if (s_fire) begin
      buffer[wr_idx] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < OUT_WORDS; k++) result[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < OUT_WORDS; k++) result[k] <= acc_fm_out[k];
    end
  end

endmodule

// File: tb/tb_cnn_host_driver.sv
// Directed-plus-random bench for cnn_host_driver with a queue-based frame model
// and a simple accelerator model with programmable done latency.
module tb_cnn_host_driver;

  localparam int DW = cnn_pkg::DATA_W;
  localparam int IW = cnn_pkg::IN_WORDS;
  localparam int OW = cnn_pkg::OUT_WORDS;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          acc_start;
  logic          acc_done = 1'b0;
  logic [DW-1:0] acc_fm_in  [0:IW-1];
  logic [DW-1:0] acc_fm_out [0:OW-1];
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          err_timeout;

  always #5 clk = ~clk;

  cnn_host_driver #(
    .DATA_W   (DW),
    .IN_WORDS (IW),
    .OUT_WORDS(OW),
    .TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .acc_start  (acc_start),
    .acc_done   (acc_done),
    .acc_fm_in  (acc_fm_in),
    .acc_fm_out (acc_fm_out),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .err_timeout(err_timeout)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] frame_q[$];
  logic [DW-1:0] ref_frame[$];
  logic [DW-1:0] exp_q[$];

  int   acc_lat     = 2;
  int   acc_cnt     = 0;
  logic res_rand    = 1'b0;
  logic force_done  = 1'b0;
  int   m_mode      = 0;
  logic s_gap       = 1'b0;
  int   last_acc_cyc = -10;
  int   start_cyc   = -1000;
  int   start_n     = 0;
  int   err_n       = 0;
  int   beats       = 0;
  int   rx_in_frame = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_last  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fm_match();
    if (ref_frame.size() != IW) return 0;
    for (int k = 0; k < IW; k++)
      if (acc_fm_in[k] !== ref_frame[k]) return 0;
    return 1;
  endfunction

  task automatic cycle();
    logic [DW-1:0] w;
    @(posedge clk);
    #1;
    cyc++;
    // accelerator model
    acc_done = force_done;
    if (acc_cnt > 0) begin
      acc_cnt--;
      if (acc_cnt == 0) begin
        acc_done = 1'b1;
        check("fm_in_stable_at_done", fm_match(), 1);
        for (int k = 0; k < OW; k++) exp_q.push_back(acc_fm_out[k]);
      end
    end
    if (acc_start) begin
      start_n++;
      start_cyc = cyc;
      check("start_after_last_word", cyc, last_acc_cyc + 1);
      ref_frame = frame_q;
      frame_q.delete();
      check("fm_in_at_start", fm_match(), 1);
      for (int k = 0; k < OW; k++)
        acc_fm_out[k] = res_rand ? DW'($urandom_range(0, 65535)) : DW'(100 + k);
      acc_cnt = acc_lat;
    end
    // source
    s_valid = (src_q.size() > 0) && (!s_gap || ($urandom_range(0, 2) != 0));
    s_data  = s_valid ? src_q[0] : DW'($urandom);
    // sink
    case (m_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ((cyc % 2) == 0);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (err_timeout) begin
      err_n++;
      check("err_timeout_cycle", cyc, start_cyc + TO + 1);
    end
    if (s_valid && s_ready) begin
      frame_q.push_back(src_q.pop_front());
      last_acc_cyc = cyc;
    end
    if (prev_stall) begin
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, prev_data);
      check("hold_last", m_last, prev_last);
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    if (m_valid && m_ready) begin
      w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      beats++;
      check("m_data", m_data, w);
      check("m_last", m_last, (rx_in_frame == OW - 1));
      rx_in_frame = (rx_in_frame + 1) % OW;
    end
  endtask

  task automatic run_until_beats(input int n, input int bound);
    int k = 0;
    while (beats < n && k < bound) begin
      cycle();
      k++;
    end
    check("beats_complete", beats, n);
  endtask

  task automatic push_frame(input logic rnd, input int base);
    for (int k = 0; k < IW; k++)
      src_q.push_back(rnd ? DW'($urandom_range(1, 65535)) : DW'(base + k));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0, s0, b0, k;
    for (int i = 0; i < OW; i++) acc_fm_out[i] = '0;

    // reset values
    reset_n = 1'b0;
    repeat (3) cycle();
    check("rst_s_ready", s_ready, 1);
    check("rst_acc_start", acc_start, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_err", err_timeout, 0);
    check("rst_fm_in_last", acc_fm_in[IW-1], 0);
    reset_n = 1'b1;

    // stray done in LOAD is ignored
    force_done = 1'b1;
    cycle();
    cycle();
    force_done = 1'b0;
    cycle();
    check("stray_done_m_valid", m_valid, 0);
    check("stray_done_s_ready", s_ready, 1);

    // frame 1..36, results 100..108, sink always ready
    push_frame(1'b0, 1);
    run_until_beats(9, 200);
    check("frame1_starts", start_n, 1);
    check("frame1_fm0", ref_frame[0], 1);
    cycle();
    check("s_ready_after_last", s_ready, 1);

    // random frame, m_ready toggling
    res_rand = 1'b1;
    m_mode   = 1;
    push_frame(1'b1, 0);
    run_until_beats(18, 400);

    // two random frames, gappy source, random sink
    s_gap  = 1'b1;
    m_mode = 2;
    push_frame(1'b1, 0);
    push_frame(1'b1, 0);
    run_until_beats(36, 1200);
    check("four_frames_started", start_n, 4);
    s_gap = 1'b0;

    // accelerator never answers
    acc_lat = 0;
    m_mode  = 0;
    e0 = err_n;
    b0 = beats;
    push_frame(1'b1, 0);
    k = 0;
    while (err_n == e0 && k < 600) begin
      cycle();
      k++;
    end
    check("timeout_pulses", err_n, e0 + 1);
    cycle();
    check("timeout_s_ready", s_ready, 1);
    check("timeout_no_beats", beats, b0);
    check("timeout_err_once", err_n, e0 + 1);

    // reset in the middle of a frame
    acc_lat = 2;
    for (int i = 0; i < 20; i++) src_q.push_back(DW'($urandom_range(1, 65535)));
    k = 0;
    while (frame_q.size() < 20 && k < 100) begin
      cycle();
      k++;
    end
    check("partial_words", frame_q.size(), 20);
    reset_n = 1'b0;
    s_valid = 1'b0;
    #1;
    check("async_rst_fm0", acc_fm_in[0], 0);
    check("async_rst_s_ready", s_ready, 1);
    src_q.delete();
    frame_q.delete();
    exp_q.delete();
    acc_cnt     = 0;
    rx_in_frame = 0;
    prev_stall  = 1'b0;
    repeat (2) cycle();
    reset_n = 1'b1;
    s0 = start_n;
    push_frame(1'b1, 0);
    run_until_beats(beats + 9, 300);
    check("post_reset_one_start", start_n, s0 + 1);

    // done arrives on the exact timeout cycle
    acc_lat = TO + 1;
    e0 = err_n;
    push_frame(1'b1, 0);
    run_until_beats(beats + 9, 700);
    check("edge_done_no_err", err_n, e0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
